// File: rtl/if_fetch_unit.sv
// if_fetch_unit: keeps the program counter, fetches one instruction word per
//   PC value from a 1-cycle-latency instruction memory and presents it until
//   the next advance request.
// Latency: advance request edge to Instr_valid=1 is 3 cycles (REQ, WAIT, HOLD).
// Backpressure: requests arriving while a fetch is in flight are parked in a
//   1-deep pending slot; a further request with the slot full is dropped and
//   sets the sticky Ovf_err flag.
//
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   PC_sel          0: PC+4, 1: PC+4+(PC_Immed<<2)   (sampled with PC_LdEn)
//   PC_LdEn         advance request, one request per high cycle
//   PC_Immed        sign-extended branch offset in words
//   Imem_rd         memory read strobe (high only while issuing a read)
//   Imem_addr       word address = PC[IMEM_AW+1:2]
//   Imem_data       read data, valid the cycle after Imem_rd
//   Instr           current instruction word
//   Instr_valid     Instr holds the word fetched from the current PC
//   PC              address of the current instruction
//   Fetch_cnt       completed fetches, wraps at 2^16
//   Ovf_err         sticky: an advance request was dropped
module if_fetch_unit #(
  parameter int IMEM_AW = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               PC_sel,
  input  logic               PC_LdEn,
  input  logic [31:0]        PC_Immed,
  output logic               Imem_rd,
  output logic [IMEM_AW-1:0] Imem_addr,
  input  logic [31:0]        Imem_data,
  output logic [31:0]        Instr,
  output logic               Instr_valid,
  output logic [31:0]        PC,
  output logic [15:0]        Fetch_cnt,
  output logic               Ovf_err
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_n;

  // 1-deep pending request slot
  logic        pend_vld, pend_vld_n;
  logic        pend_sel, pend_sel_n;
  logic [31:0] pend_imm, pend_imm_n;

  // advance decision for this cycle and the operands it uses
  logic        adv;
  logic        adv_sel;
  logic [31:0] adv_imm;
  logic [31:0] pc_next;
  logic        ovf_set;

  always_comb begin
    state_n    = state;
    pend_vld_n = pend_vld;
    pend_sel_n = pend_sel;
    pend_imm_n = pend_imm;
    adv        = 1'b0;
    adv_sel    = PC_sel;
    adv_imm    = PC_Immed;
    ovf_set    = 1'b0;

    case (state)
      S_BOOT: state_n = S_REQ;
      S_REQ:  state_n = S_WAIT;
      S_WAIT: state_n = S_HOLD;
      S_HOLD: begin
        if (pend_vld) begin
          // Parked request goes first; a live request in the same cycle
          // refills the slot that was just emptied.
          adv        = 1'b1;
          adv_sel    = pend_sel;
          adv_imm    = pend_imm;
          state_n    = S_REQ;
          pend_vld_n = PC_LdEn;
          if (PC_LdEn) begin
            pend_sel_n = PC_sel;
            pend_imm_n = PC_Immed;
          end
        end else if (PC_LdEn) begin
          adv     = 1'b1;
          state_n = S_REQ;
        end
      end
      default: state_n = S_BOOT;
    endcase

    // Outside HOLD a fetch is in flight: park the request or drop it.
    if (state != S_HOLD && PC_LdEn) begin
      if (!pend_vld) begin
        pend_vld_n = 1'b1;
        pend_sel_n = PC_sel;
        pend_imm_n = PC_Immed;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  // Offset is in words; shifting keeps PC word-aligned, arithmetic wraps mod 2^32.
  assign pc_next   = PC + 32'd4 + (adv_sel ? {adv_imm[29:0], 2'b00} : 32'd0);
  assign Imem_rd   = (state == S_REQ);
  assign Imem_addr = PC[IMEM_AW+1:2];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_BOOT;
      PC          <= 32'd0;
      Instr       <= 32'd0;
      Instr_valid <= 1'b0;
      Fetch_cnt   <= 16'd0;
      Ovf_err     <= 1'b0;
      pend_vld    <= 1'b0;
      pend_sel    <= 1'b0;
      pend_imm    <= 32'd0;
    end else begin
      state    <= state_n;
      pend_vld <= pend_vld_n;
      pend_sel <= pend_sel_n;
      pend_imm <= pend_imm_n;
      if (adv) begin
        PC          <= pc_next;
        Instr_valid <= 1'b0;
      end
      // Read data arrives during WAIT; capture it on the way out.
      if (state == S_WAIT) begin
        Instr       <= Imem_data;
        Instr_valid <= 1'b1;
        Fetch_cnt   <= Fetch_cnt + 16'd1;
      end
      if (ovf_set) begin
        Ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter IMEM_AW, default 10: word-address width of the instruction memory.
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PC_sel  input  1  next-PC select, sampled with PC_LdEn: 0 = PC+4, 1 = PC+4+(PC_Immed<<2).
REQ-005 PC_LdEn  input  1  advance request; each cycle it is high counts as one request.
REQ-006 PC_Immed  input  32  sign-extended branch offset in words.
REQ-007 Imem_rd  output  1  instruction-memory read strobe.
REQ-008 Imem_addr  output  IMEM_AW  word address, equal to PC[IMEM_AW+1:2].
REQ-009 Imem_data  input  32  read data, valid exactly 1 cycle after the Imem_rd cycle.
REQ-010 Instr  output  32  current instruction, held stable between fetches.
REQ-011 Instr_valid  output  1  high while Instr holds the word fetched from the current PC.
REQ-012 PC  output  32  address of the current instruction.
REQ-013 Fetch_cnt  output  16  number of completed fetches, wraps modulo 2^16.
REQ-014 Ovf_err  output  1  sticky: an advance request was dropped.

Function
REQ-015 FSM states: BOOT, REQ, WAIT, HOLD; Reset forces BOOT.
REQ-016 Transitions: BOOT->REQ; REQ->WAIT; WAIT->HOLD; HOLD->REQ on an accepted request; otherwise HOLD->HOLD.
REQ-017 Imem_rd is combinational and equals 1 only in REQ; Imem_addr is driven from PC in every state.
REQ-018 WAIT: Instr<=Imem_data, Instr_valid<=1, Fetch_cnt<=Fetch_cnt+1 at the edge leaving WAIT.
REQ-019 Request in HOLD (PC_LdEn=1): PC<=PC+4 when PC_sel=0, PC<=PC+4+(PC_Immed<<2) when PC_sel=1; Instr_valid<=0 at the same edge; all arithmetic is 32-bit modulo 2^32.
REQ-020 Request in BOOT/REQ/WAIT: PC_sel and PC_Immed are captured into a 1-deep pending slot, if empty.
REQ-021 Pending slot: consumed on the first HOLD cycle exactly as in REQ-019 using the captured values; live PC_LdEn in that cycle is treated as a new request.
REQ-022 Pending slot full and a further request outside HOLD: the request is dropped; Ovf_err<=1 until Reset.
REQ-023 HOLD with pending slot full and live PC_LdEn=1: pending is consumed; the live request is captured into the now-empty slot; no overflow.
REQ-024 Fetch latency: the request edge to Instr_valid=1 is 3 cycles (HOLD->REQ->WAIT->HOLD).
REQ-025 PC is always word-aligned, PC[1:0]=0.
REQ-026 PC beyond the memory size wraps via Imem_addr truncation.

Reset
REQ-027 With Reset=1 at an edge: PC=0, Instr=0, Instr_valid=0, Fetch_cnt=0, Ovf_err=0, pending empty, state=BOOT, hence Imem_rd=0.
REQ-028 Reset mid-fetch (REQ or WAIT) aborts the fetch; Imem_data returning afterwards is ignored.
REQ-029 After Reset falls, the word at address 0 is fetched automatically; Instr_valid=1 is reached 3 cycles after the first non-reset edge.

Verification
REQ-030 Reset then idle, mem[0]=0x8000_0030 -> Imem_rd pulse with addr 0; Instr=0x8000_0030; Instr_valid=1; PC=0; Fetch_cnt=1.
REQ-031 HOLD, PC=0x10, PC_LdEn pulse with PC_sel=0 -> PC=0x14; Imem_addr=5; Instr_valid low for 3 cycles, then the new word is presented.
REQ-032 PC=0x40, PC_sel=1, PC_Immed=0xFFFF_FFFC -> PC=0x34; with PC_Immed=3 -> PC=0x50.
REQ-033 Two PC_LdEn pulses during REQ and WAIT -> first is served on reaching HOLD; second sets Ovf_err=1; final PC=old PC+4.
REQ-034 PC=0xFFFF_FFFC, PC_sel=0 -> PC=0x0000_0000; Fetch_cnt at 0xFFFF wraps to 0 on the next fetch.
REQ-035 Reset asserted during WAIT -> Instr=0, Instr_valid=0; refetch from address 0.
